// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, widths and sequencer state type for the ALU block
package alu_pkg;
    localparam int ALU_W = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_SHL = 2'b11;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_t;
endpackage

// File: rtl/alu.sv
// alu: 8-bit combinational ALU; carry always reflects a+b
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [1:0]       sel,
    output logic [ALU_W-1:0] out,
    output logic             carry,
    output logic             zero
);
    logic [ALU_W:0]     sum;
    logic [2*ALU_W-1:0] prod;
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        prod  = a * b;
        out   = sel == OP_ADD ? sum[ALU_W-1:0] :
                sel == OP_MUL ? prod[ALU_W-1:0] :
                sel == OP_XOR ? a ^ b : {a[ALU_W-2:0], 1'b0};
        carry = sum[ALU_W];
        zero  = out == '0;
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: sequencer wired to the combinational ALU for system use
module alu_unit
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    logic [ALU_W-1:0] alu_a, alu_b, alu_out;
    logic [1:0]       alu_sel;
    logic             alu_carry, alu_zero;
    alu_cmd_sequencer #(.CNT_W(CNT_W)) u_seq (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );
    alu u_alu (
        .a(alu_a), .b(alu_b), .sel(alu_sel),
        .out(alu_out), .carry(alu_carry), .zero(alu_zero)
    );
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end driving an external ALU
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    seq_state_t state, state_nxt;
    logic [ALU_W-1:0] acc;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cmd_valid ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_ADD;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                alu_a   <= cmd_chain ? acc : cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_op;
            end
            // raw ALU carry is only meaningful for ADD
            if (state == EXEC) begin
                rsp_data  <= alu_out;
                rsp_zero  <= alu_zero;
                rsp_carry <= (alu_sel == OP_ADD) && alu_carry;
                acc       <= alu_out;
            end
            if (state == RESP && rsp_ready)
                op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with a transaction-level model checked every cycle
module tb_alu_cmd_sequencer;
    import alu_pkg::*;
    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_chain = 0, rsp_ready = 1;
    logic [1:0] cmd_op = 0;
    logic [7:0] cmd_a = 0, cmd_b = 0;
    logic cmd_ready, rsp_valid, rsp_carry, rsp_zero, busy;
    logic [7:0] alu_a, alu_b, alu_out, rsp_data;
    logic [1:0] alu_sel;
    logic alu_carry, alu_zero;
    logic [15:0] op_count;
    logic cmd_ready2, rsp_valid2, rsp_carry2, rsp_zero2, busy2;
    logic [7:0] alu_a2, alu_b2, alu_out2, rsp_data2;
    logic [1:0] alu_sel2;
    logic alu_carry2, alu_zero2;
    logic [1:0] op_count2;
    int total = 0, passed = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    // stand-in for the external ALU: {carry, out}
    function automatic logic [8:0] alu_f(logic [7:0] a, logic [7:0] b, logic [1:0] s);
        logic [8:0] sum;
        logic [15:0] p;
        sum = a + b;
        p = a * b;
        case (s)
            2'b00:   return sum;
            2'b01:   return {sum[8], p[7:0]};
            2'b10:   return {sum[8], a ^ b};
            default: return {sum[8], a[6:0], 1'b0};
        endcase
    endfunction
    assign {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);
    assign alu_zero = alu_out == 0;
    assign {alu_carry2, alu_out2} = alu_f(alu_a2, alu_b2, alu_sel2);
    assign alu_zero2 = alu_out2 == 0;

    alu_cmd_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );
    alu_cmd_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_out(alu_out2),
        .alu_carry(alu_carry2), .alu_zero(alu_zero2), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_carry(rsp_carry2),
        .rsp_zero(rsp_zero2), .busy(busy2), .op_count(op_count2)
    );

    // transaction model: an accepted command yields one response a cycle later
    int m_a = 0, m_b = 0, m_sel = 0, m_acc = 0, m_data = 0, m_carry = 0, m_zero = 0, m_cnt = 0;
    bit m_ready = 1, m_exec = 0, m_rv = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = 0; m_b = 0; m_sel = 0; m_acc = 0; m_data = 0; m_carry = 0; m_zero = 0; m_cnt = 0;
            m_ready = 1; m_exec = 0; m_rv = 0;
        end else if (m_ready && cmd_valid) begin
            m_a = cmd_chain ? m_acc : int'(cmd_a);
            m_b = int'(cmd_b);
            m_sel = int'(cmd_op);
            m_ready = 0;
            m_exec = 1;
        end else if (m_exec) begin
            case (m_sel)
                0:       m_data = (m_a + m_b) % 256;
                1:       m_data = (m_a * m_b) % 256;
                2:       m_data = m_a ^ m_b;
                default: m_data = (m_a * 2) % 256;
            endcase
            m_carry = (m_sel == 0 && m_a + m_b > 255) ? 1 : 0;
            m_zero = m_data == 0 ? 1 : 0;
            m_acc = m_data;
            m_exec = 0;
            m_rv = 1;
        end else if (m_rv && rsp_ready) begin
            m_rv = 0;
            m_cnt++;
            m_ready = 1;
        end
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("cmd_ready", int'(cmd_ready), int'(m_ready));
        chk("rsp_valid", int'(rsp_valid), int'(m_rv));
        chk("busy", int'(busy), int'(!m_ready));
        chk("alu_a", int'(alu_a), m_a);
        chk("alu_b", int'(alu_b), m_b);
        chk("alu_sel", int'(alu_sel), m_sel);
        chk("rsp_data", int'(rsp_data), m_data);
        chk("rsp_carry", int'(rsp_carry), m_carry);
        chk("rsp_zero", int'(rsp_zero), m_zero);
        chk("op_count", int'(op_count), m_cnt % 65536);
        chk("op_count2", int'(op_count2), m_cnt % 4);
        chk("rsp_valid2", int'(rsp_valid2), int'(m_rv));
    end

    // issue a command, release cmd_valid after accept, return at the negedge where rsp_valid is up
    task automatic do_cmd(logic [1:0] op, logic [7:0] a, logic [7:0] b, logic ch);
        int n;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("rsp_timeout", int'(rsp_valid), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_op_count", int'(op_count), 0);
        rst = 0;
        chk_en = 1;
        do_cmd(OP_ADD, 8'hF0, 8'h20, 0);
        chk("add_data", int'(rsp_data), 'h10);
        chk("add_carry", int'(rsp_carry), 1);
        chk("add_zero", int'(rsp_zero), 0);
        @(negedge clk);
        chk("add_count", int'(op_count), 1);
        do_cmd(OP_XOR, 8'hFF, 8'hFF, 0);
        chk("xor_data", int'(rsp_data), 0);
        chk("xor_zero", int'(rsp_zero), 1);
        chk("xor_carry_masked", int'(rsp_carry), 0);
        do_cmd(OP_ADD, 8'h03, 8'h04, 0);
        chk("add7_data", int'(rsp_data), 'h07);
        do_cmd(OP_SHL, 8'hAA, 8'h00, 1);
        chk("shl_chain_a", int'(alu_a), 'h07);
        chk("shl_data", int'(rsp_data), 'h0E);
        do_cmd(OP_MUL, 8'hAA, 8'h20, 1);
        chk("mul_chain_data", int'(rsp_data), 'hC0);
        // back-pressure with cmd_valid held high
        @(negedge clk);
        cmd_valid = 1; cmd_op = OP_ADD; cmd_a = 1; cmd_b = 2; cmd_chain = 0; rsp_ready = 0;
        @(negedge clk);
        cmd_op = OP_XOR; cmd_a = 5; cmd_b = 3;
        @(negedge clk);
        chk("bp_valid", int'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", int'(rsp_data), 3);
            chk("bp_ready", int'(cmd_ready), 0);
            chk("bp_count", int'(op_count), 5);
            if (i == 4) rsp_ready = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        chk("bp_release_count", int'(op_count), 6);
        chk("bp_release_ready", int'(cmd_ready), 1);
        @(negedge clk);
        chk("bp_second_accepted", int'(cmd_ready), 0);
        chk("bp_second_a", int'(alu_a), 5);
        chk("bp_second_sel", int'(alu_sel), int'(OP_XOR));
        cmd_valid = 0;
        @(negedge clk);
        chk("bp_second_data", int'(rsp_data), 6);
        @(negedge clk);
        chk("bp_count_after", int'(op_count), 7);
        // reset while in EXEC
        @(negedge clk);
        cmd_valid = 1; cmd_op = OP_ADD; cmd_a = 8'h11; cmd_b = 8'h22; cmd_chain = 0;
        @(negedge clk);
        cmd_valid = 0;
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_alu_a", int'(alu_a), 0);
        chk("mid_rst_count", int'(op_count), 0);
        chk("mid_rst_data", int'(rsp_data), 0);
        #1 rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("no_rsp_after_rst", int'(rsp_valid), 0);
        end
        do_cmd(OP_ADD, 8'hAA, 8'h05, 1);
        chk("acc_cleared", int'(rsp_data), 5);
        @(negedge clk);
        chk("cnt2_1", int'(op_count2), 1);
        do_cmd(OP_ADD, 8'h09, 8'h09, 0);
        chk("post_rst_data", int'(rsp_data), 'h12);
        @(negedge clk);
        chk("cnt2_2", int'(op_count2), 2);
        do_cmd(OP_MUL, 8'h10, 8'h10, 0);
        chk("mul_trunc_zero", int'(rsp_zero), 1);
        @(negedge clk);
        chk("cnt2_3", int'(op_count2), 3);
        do_cmd(OP_SHL, 8'h81, 8'h00, 0);
        chk("shl_trunc", int'(rsp_data), 2);
        @(negedge clk);
        chk("cnt2_wrap", int'(op_count2), 0);
        chk("cnt16_4", int'(op_count), 4);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
